max_reduce_sched: RTL and testbench
===================================

// Module: max_reduce_sched
// PURPOSE
//   Shares one combinational 32-bit unsigned max/select unit between NREQ requesters.
//   Each requester streams a packet of operands. The block arbitrates packets round-robin,
//   holds a grant for a whole packet, and folds each beat into a running maximum.
//   It returns one result per packet with the winning requester's id and a beat count.
//   It sits in front of the max/select netlist benchmarks and sequences them as a reusable reduction engine.
// PARAMETERS
//   W     32  operand/result width (unsigned)
//   NREQ  4   number of requesters (>=2)
//   IDW   $clog2(NREQ)  requester id width (derived, not overridden)
//   CNTW  16  beat counter width
// PORTS
//   clk        in   1         single clock, rising edge
//   rst_n      in   1         synchronous reset, active-low
//   req_valid  in   NREQ      per-requester beat valid
//   req_data   in   NREQ*W    per-requester operand; requester i at [i*W +: W]
//   req_last   in   NREQ      final beat of packet, qualified by req_valid
//   req_ready  out  NREQ      per-requester beat accept
//   res_valid  out  1         result available
//   res_ready  in   1         result consumer accept
//   res_data   out  W         max of all beats in the packet
//   res_id     out  IDW       requester that owned the packet
//   res_count  out  CNTW      beats accepted in packet, saturating
//   busy       out  1         state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): state=IDLE, rr_ptr=0, acc=0, cnt=0, grant=0.
//     All outputs 0; req_ready=0.
//     Reset mid-packet abandons the packet; no partial result is produced.
//   Beat handshake: a beat transfers when req_valid[i] & req_ready[i] at clk.
//   Result handshake: transfers when res_valid & res_ready.
//   FSM:
//     IDLE: req_ready=0. If any req_valid, grant = first valid index searching rr_ptr, rr_ptr+1, ... (mod NREQ).
//       Registered: acc<=0, cnt<=0, ->ACCUM. No beat is consumed in IDLE.
//     ACCUM: req_ready = onehot(grant); all others 0.
//       On beat: acc <= max_u(acc, data[grant]); cnt <= sat(cnt+1).
//       If the beat has req_last, ->DONE. With no beat, hold.
//     DONE: res_valid=1; res_data=acc, res_id=grant, res_count=cnt, all held stable.
//       On res_ready: ->IDLE, rr_ptr <= (grant+1) mod NREQ.
//   Latency: res_valid rises the cycle after the last beat is accepted.
//     Min packet period = beats+2 cycles: IDLE grant cycle + beats + DONE cycle, with res_ready=1.
//   Arithmetic:
//     max is an unsigned W-bit compare; on a tie acc is kept.
//     acc=0 is the identity, so a packet of all-zero beats returns 0.
//     cnt saturates at 2^CNTW-1 and does not wrap; acc keeps updating after saturation.
//   Boundaries:
//     Single-beat packet (valid & last on first beat): result = that operand, count=1.
//     Requester drops valid mid-packet: grant held; no timeout.
//     All NREQ valid: grants rotate 0,1,2,3,0...
//     Only one requester valid: it is regranted back-to-back despite rr_ptr.
//     req_last without req_valid is ignored.
//     Other requesters' valid/last during ACCUM/DONE are ignored and not consumed.
//     res_ready while not DONE is ignored.
// STRUCTURE
//   Package max_sched_pkg: state enum {IDLE, ACCUM, DONE}; default W/CNTW localparams;
//     function rr_pick(valid, ptr) returning the id.
//   Sub-module max_sel (combinational, W-bit): y = (a > b unsigned) ? a : b, i.e. b ^ (gt & (a^b)).
//     One instance, inputs acc and the granted operand, output feeds acc.
//   Operand mux, registered grant/acc/cnt/rr_ptr, and FSM stay in max_reduce_sched.
// TESTING
//   1. Req0 beats 0x5,0xFFFF_FFFE,0x7(last), res_ready=1
//      -> res_data=0xFFFF_FFFE, res_id=0, res_count=3; res_valid 1 cycle after beat 3.
//   2. All 4 valid with 1-beat packets 0x10,0x20,0x30,0x40 held valid
//      -> results in id order 0,1,2,3,0; req_ready one-hot and only to grant.
//   3. Req2 beats 0x8000_0000, 0x7FFF_FFFF(last)
//      -> 0x8000_0000 (unsigned compare); equal beats 0xA,0xA -> 0xA, count=2.
//   4. DONE with res_ready=0 for 5 cycles while req1 valid
//      -> outputs stable, req_ready=0; after accept, IDLE then grant req1.
//   5. rst_n=0 for 1 cycle after 2 of 4 beats
//      -> next cycle all outputs 0, state IDLE; no result emitted; rr_ptr=0.
//   6. CNTW=4, 20-beat packet -> res_count=15, res_data = true max of all 20 beats.

Source files
------------

// File: rtl/max_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : max_sched_pkg
//  Description : Shared types and helpers for the max-reduction scheduler.
//                - state_t  : scheduler FSM states
//                - C_DEFAULT_W / C_DEFAULT_CNTW : default operand and beat
//                  counter widths
//                - rr_pick  : round-robin pick of the first valid requester
//                  starting at a pointer, wrapping modulo nreq
//  Revision    : 1.0 - initial release
// ============================================================================
package max_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int C_DEFAULT_W    = 32;
    localparam int C_DEFAULT_CNTW = 16;

    // Upper bound on the requester count that rr_pick can scan.
    localparam int C_MAX_NREQ     = 32;

    // Returns the index of the first set bit of valid[nreq-1:0], scanning
    // ptr, ptr+1, ... modulo nreq. Returns 0 when nothing is valid; callers
    // only use the result when at least one bit is set. ptr must be < nreq.
    function automatic int rr_pick(
        input logic [C_MAX_NREQ-1:0] valid,
        input int                    ptr,
        input int                    nreq
    );
        int   idx;
        logic found;
        rr_pick = 0;
        found   = 1'b0;
        for (int k = 0; k < C_MAX_NREQ; k++) begin
            // ptr and k are both below nreq, so one subtraction wraps.
            idx = ptr + k;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if ((k < nreq) && !found && valid[idx[4:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage : max_sched_pkg
`default_nettype wire

// File: rtl/max_sel.sv
`default_nettype none
// ============================================================================
//  Module      : max_sel
//  Description : Combinational W-bit unsigned max/select.
//                o_y = (i_a > i_b) ? i_a : i_b, built as i_b ^ (gt & (i_a^i_b)).
//                On a tie i_b passes through, so wiring the running
//                accumulator to i_b keeps the accumulator on equal operands.
//  Ports       : i_a  [W-1:0]  candidate operand
//                i_b  [W-1:0]  incumbent value (kept on tie)
//                o_y  [W-1:0]  selected maximum
//  Revision    : 1.0 - initial release
// ============================================================================
module max_sel #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
);

    logic w_gt;

    assign w_gt = (i_a > i_b);
    assign o_y  = i_b ^ ({W{w_gt}} & (i_a ^ i_b));

endmodule : max_sel
`default_nettype wire

// File: rtl/max_reduce_sched.sv
`default_nettype none
// ============================================================================
//  Module      : max_reduce_sched
//  Description : Shares one max/select unit between NREQ requesters. Packets
//                are arbitrated round-robin, a grant is held for a whole
//                packet, and every accepted beat is folded into a running
//                unsigned maximum. One result (max, owner id, saturating beat
//                count) is returned per packet.
//  Ports       : clk        clock, rising edge
//                rst_n      synchronous reset, active-low
//                req_valid  [NREQ]      per-requester beat valid
//                req_data   [NREQ*W]    operands, requester i at [i*W +: W]
//                req_last   [NREQ]      final beat of packet (with valid)
//                req_ready  [NREQ]      per-requester beat accept
//                res_valid              result available
//                res_ready              result consumer accept
//                res_data   [W]         max of all beats in the packet
//                res_id     [IDW]       requester that owned the packet
//                res_count  [CNTW]      beats in packet, saturating
//                busy                   scheduler not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module max_reduce_sched
    import max_sched_pkg::*;
#(
    parameter  int W    = C_DEFAULT_W,
    parameter  int NREQ = 4,
    parameter  int CNTW = C_DEFAULT_CNTW,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_data,
    output logic [IDW-1:0]    res_id,
    output logic [CNTW-1:0]   res_count,
    output logic              busy
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDW-1:0]      r_grant;
    logic [IDW-1:0]      r_rr_ptr;
    logic [W-1:0]        r_acc;
    logic [CNTW-1:0]     r_cnt;

    logic [C_MAX_NREQ-1:0] w_valid_ext;
    logic                  w_any_valid;
    logic [IDW-1:0]        w_pick;
    logic [IDW-1:0]        w_grant_inc;
    logic [W-1:0]          w_operand;
    logic [W-1:0]          w_max;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_res_take;

    // ------------------------------------------------------------------
    // Arbitration and operand selection
    // ------------------------------------------------------------------
    assign w_valid_ext = C_MAX_NREQ'(req_valid);
    assign w_any_valid = |req_valid;
    assign w_pick      = IDW'(rr_pick(w_valid_ext, int'(r_rr_ptr), NREQ));

    // Next pointer after the current owner; NREQ need not be a power of 2.
    assign w_grant_inc = (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + 1'b1;

    assign w_operand   = req_data[r_grant*W +: W];

    // Only the granted requester's valid/last matter; the rest are ignored.
    assign w_beat      = (r_state == ACCUM) && req_valid[r_grant];
    assign w_last_beat = w_beat && req_last[r_grant];
    assign w_res_take  = (r_state == DONE) && res_ready;

    // The accumulator sits on the tie-keeping input of the selector.
    max_sel #(
        .W (W)
    ) u_max_sel (
        .i_a (w_operand),
        .i_b (r_acc),
        .o_y (w_max)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        res_valid   = 1'b0;
        res_data    = '0;
        res_id      = '0;
        res_count   = '0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                req_ready = NREQ'(1) << r_grant;
                if (w_last_beat) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                res_data  = r_acc;
                res_id    = r_grant;
                res_count = r_cnt;
                if (res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant, accumulator, beat counter and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            if ((r_state == IDLE) && w_any_valid) begin
                r_grant <= w_pick;
                r_acc   <= '0;
                r_cnt   <= '0;
            end
            if (w_beat) begin
                r_acc <= w_max;
                // Count saturates; the max keeps folding regardless.
                if (r_cnt != {CNTW{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_res_take) begin
                r_rr_ptr <= w_grant_inc;
            end
        end
    end

endmodule : max_reduce_sched
`default_nettype wire

// File: tb/tb_max_reduce_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_max_reduce_sched
//  Description : Self-checking bench for max_reduce_sched. Packets are queued
//                per requester; expected results (max, id, saturated count)
//                and their round-robin order are computed from the packet
//                lists before each round is run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_max_reduce_sched;

    localparam int W       = 32;
    localparam int NREQ    = 4;
    localparam int TB_CNTW = 4;
    localparam int IDW     = 2;
    localparam int CNT_MAX = (1 << TB_CNTW) - 1;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] id;
        logic [31:0] cnt;
    } res_t;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_data;
    logic [IDW-1:0]    res_id;
    logic [TB_CNTW-1:0] res_count;
    logic              busy;

    int n_checks;
    int n_fail;

    // Per-requester beat queues, packet summaries and the expected result
    // stream in round-robin order.
    logic [31:0] q_data  [NREQ][$];
    bit          q_last  [NREQ][$];
    bit          started [NREQ];
    res_t        pk_q    [NREQ][$];
    res_t        exp_q   [$];
    logic [31:0] pkt     [$];
    int          m_ptr;
    int          p_ready;
    bit          gaps;
    int          stall_left;

    max_reduce_sched #(
        .W    (W),
        .NREQ (NREQ),
        .CNTW (TB_CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_count (res_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Turns pkt into a packet for requester i and records its summary.
    task automatic add_packet(input int i);
        res_t r;
        r.d   = '0;
        r.id  = i;
        r.cnt = '0;
        foreach (pkt[k]) begin
            q_data[i].push_back(pkt[k]);
            q_last[i].push_back(k == pkt.size() - 1);
            if (pkt[k] > r.d) r.d = pkt[k];
        end
        r.cnt = (pkt.size() > CNT_MAX) ? CNT_MAX : pkt.size();
        pk_q[i].push_back(r);
        pkt.delete();
    endtask

    // Orders all queued packets: each time, the first requester with a
    // packet pending at or after the pointer wins; pointer moves past it.
    task automatic predict();
        bit any;
        int id;
        do begin
            any = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                id = (m_ptr + k) % NREQ;
                if (!any && pk_q[id].size() > 0) begin
                    any = 1'b1;
                    exp_q.push_back(pk_q[id].pop_front());
                    m_ptr = (id + 1) % NREQ;
                end
            end
        end while (any);
    endtask

    task automatic flush_model();
        for (int i = 0; i < NREQ; i++) begin
            q_data[i].delete();
            q_last[i].delete();
            pk_q[i].delete();
            started[i] = 1'b0;
        end
        exp_q.delete();
        m_ptr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        flush_model();
    endtask

    task automatic run_round(input int budget);
        bit          in_done;
        bit          idle_chk;
        int          cyc;
        res_t        e;
        logic [3:0]  v;
        logic [3:0]  onehot;
        in_done  = 1'b0;
        idle_chk = 1'b0;
        cyc      = 0;
        predict();
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc > budget) begin
                chk("round_timeout_pending", 64'(exp_q.size()), 64'd0);
                do_reset();
                return;
            end
            chk("res_valid", res_valid, in_done);
            if (idle_chk) begin
                chk("idle_ready", req_ready, 4'b0);
                chk("idle_busy", busy, 1'b0);
                idle_chk = 1'b0;
            end
            if (in_done) begin
                e = exp_q[0];
                chk("res_data", res_data, e.d);
                chk("res_id", res_id, e.id);
                chk("res_count", res_count, e.cnt);
                chk("done_ready", req_ready, 4'b0);
                chk("done_busy", busy, 1'b1);
            end else if (exp_q.size() > 0 && req_ready != '0) begin
                onehot = 4'b1 << exp_q[0].id;
                chk("grant_onehot", req_ready, onehot);
                chk("accum_busy", busy, 1'b1);
            end
            if (exp_q.size() == 0 && !in_done) break;

            // Drive requesters: pending first beats are held valid; the
            // owner of a started packet may insert random gaps.
            v = '0;
            for (int i = 0; i < NREQ; i++) begin
                logic [31:0] d;
                bit          l;
                bit          en;
                d  = $urandom;
                l  = 1'($urandom % 2);
                en = 1'b0;
                if (q_data[i].size() > 0) begin
                    en = !(gaps && started[i] && ($urandom % 3 == 0));
                    if (en) begin
                        d = q_data[i][0];
                        l = q_last[i][0];
                    end
                end
                v[i]              = en;
                req_data[i*W +: W] = d;
                req_last[i]       = l;
            end
            req_valid = v;

            if (in_done && stall_left > 0) begin
                res_ready  = 1'b0;
                stall_left--;
            end else begin
                res_ready = (int'($urandom % 100) < p_ready);
            end

            // Transfers that happen at the coming rising edge.
            if (res_valid && res_ready && in_done) begin
                void'(exp_q.pop_front());
                in_done  = 1'b0;
                idle_chk = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (v[i] && req_ready[i]) begin
                    if (q_last[i][0]) begin
                        in_done    = 1'b1;
                        started[i] = 1'b0;
                    end else begin
                        started[i] = 1'b1;
                    end
                    void'(q_data[i].pop_front());
                    void'(q_last[i].pop_front());
                end
            end
        end
    endtask

    initial begin
        int          n;
        logic [31:0] prev;
        logic [31:0] b;
        int          len;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        res_ready  = 1'b0;
        p_ready    = 100;
        gaps       = 1'b0;
        stall_left = 0;
        flush_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 4'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_res_id", res_id, 2'd0);
        chk("rst_res_count", res_count, 4'd0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Three-beat packet on requester 0.
        pkt = '{32'h5, 32'hFFFF_FFFE, 32'h7};
        add_packet(0);
        run_round(200);

        // All four requesters valid with single-beat packets.
        pkt = '{32'h10}; add_packet(0);
        pkt = '{32'h20}; add_packet(1);
        pkt = '{32'h30}; add_packet(2);
        pkt = '{32'h40}; add_packet(3);
        pkt = '{32'h11}; add_packet(0);
        run_round(200);

        // Unsigned compare, ties, and an all-zero packet.
        pkt = '{32'h8000_0000, 32'h7FFF_FFFF}; add_packet(2);
        pkt = '{32'hA, 32'hA}; add_packet(2);
        pkt = '{32'h0, 32'h0, 32'h0}; add_packet(3);
        run_round(200);

        // Result back-pressure for 5 cycles while another requester waits.
        pkt = '{32'h123, 32'h45}; add_packet(0);
        pkt = '{32'h99}; add_packet(1);
        stall_left = 5;
        run_round(200);

        // 20-beat packet: count saturates, max still tracks every beat.
        for (int k = 0; k < 20; k++) pkt.push_back($urandom);
        add_packet(0);
        run_round(400);

        // Leave the pointer at 2, then reset part-way through a packet.
        pkt = '{32'h77}; add_packet(1);
        run_round(200);
        n = 0;
        for (int c = 0; c < 50 && n < 2; c++) begin
            @(negedge clk);
            req_valid         = 4'b0010;
            req_data[W +: W]  = 32'hA0 + n;
            req_last          = 4'b0000;
            res_ready         = 1'b1;
            if (req_ready[1]) n++;
        end
        chk("pre_rst_beats", n, 2);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("mid_rst_req_ready", req_ready, 4'b0);
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_res_data", res_data, 32'h0);
        chk("mid_rst_res_id", res_id, 2'd0);
        chk("mid_rst_res_count", res_count, 4'd0);
        chk("mid_rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_no_result", res_valid, 1'b0);
        end
        flush_model();
        for (int i = 0; i < NREQ; i++) begin
            pkt = '{32'h200 + i};
            add_packet(i);
        end
        run_round(200);

        // Randomized rounds with gaps and result back-pressure.
        gaps = 1'b1;
        for (int r = 0; r < 40; r++) begin
            p_ready = 50 + int'($urandom % 51);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom % 4 != 0) begin
                    for (int p = 0; p < 1 + int'($urandom % 3); p++) begin
                        len  = ($urandom % 8 == 0) ? 17 + int'($urandom % 4)
                                                   : 1 + int'($urandom % 5);
                        prev = $urandom;
                        for (int k = 0; k < len; k++) begin
                            case ($urandom % 8)
                                0:       b = 32'h0;
                                1:       b = 32'hFFFF_FFFF;
                                2:       b = prev;
                                default: b = $urandom;
                            endcase
                            prev = b;
                            pkt.push_back(b);
                        end
                        add_packet(i);
                    end
                end
            end
            run_round(5000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_max_reduce_sched
`default_nettype wire
